// File: rtl/fir_sm_rdbuf.sv
// Read-side buffer for the FIR engine's Yn stream. Samples arriving on the
// sm_* AXI-Stream port are queued in a small FIFO and handed to the CPU via
// Wishbone reads of Y_DATA, alongside a STATUS register and a write-only
// CTRL register (flush / clear).
module fir_sm_rdbuf #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH_LOG2 = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  input  logic                   sm_tvalid,
  input  logic [pDATA_WIDTH-1:0] sm_tdata,
  input  logic                   sm_tlast,
  output logic                   sm_tready,
  output logic                   frame_done_o
);

  localparam int DEPTH = 1 << pDEPTH_LOG2;
  localparam int PW    = pDEPTH_LOG2;
  localparam int CW    = pDEPTH_LOG2 + 1;

  localparam logic [31:0] ADR_Y_DATA = 32'h3000_0080;
  localparam logic [31:0] ADR_STATUS = 32'h3000_0084;
  localparam logic [31:0] ADR_CTRL   = 32'h3000_0088;

  // Registered state
  logic                 ack_q, ack_d;
  logic [31:0]          dat_q, dat_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 last_seen_q, last_seen_d;
  logic                 underflow_q, underflow_d;
  logic [15:0]          pushed_q, pushed_d;

  // Entry layout: {tlast, tdata}
  logic [pDATA_WIDTH:0] fifo_mem [DEPTH];
  logic [pDATA_WIDTH:0] head_entry;

  // Decode / status
  logic        req, hit_y, hit_s, hit_c;
  logic        empty, full, head_last;
  logic        flush_now, clear_now, push, pop, underrun;
  logic [31:0] status_word;

  // Byte selects and the unused CTRL bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{wbs_sel_i, wbs_dat_i[31:2]};

  assign req   = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign hit_y = (wbs_adr_i == ADR_Y_DATA);
  assign hit_s = (wbs_adr_i == ADR_STATUS);
  assign hit_c = (wbs_adr_i == ADR_CTRL);

  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign head_entry = fifo_mem[rd_ptr_q];
  assign head_last  = ~empty & head_entry[pDATA_WIDTH];

  assign flush_now = req & wbs_we_i & hit_c & wbs_dat_i[0];
  assign clear_now = req & wbs_we_i & hit_c & wbs_dat_i[1];

  // Ready depends on current occupancy only; a same-cycle pop does not free
  // a slot, and a flush cycle refuses data so nothing is dropped silently.
  assign sm_tready = ~full & ~flush_now;
  assign push      = sm_tvalid & sm_tready;
  assign pop       = req & ~wbs_we_i & hit_y & ~empty;
  assign underrun  = req & ~wbs_we_i & hit_y & empty;

  assign status_word = {pushed_q, 8'(count_q), 3'b000,
                        head_last, underflow_q, last_seen_q, full, empty};

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;
  assign frame_done_o = last_seen_q;

  // Next-state: bus response, pointer/count update, sticky flags
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    ack_d       = req & (hit_y | hit_s | hit_c);
    dat_d       = dat_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    last_seen_d = last_seen_q;
    underflow_d = underflow_q;
    pushed_d    = pushed_q;

    if (req & ~wbs_we_i) begin
      if (hit_y)      dat_d = empty ? '0 : 32'(head_entry[pDATA_WIDTH-1:0]);
      else if (hit_s) dat_d = status_word;
      else if (hit_c) dat_d = '0;
    end

    if (pop)      rd_ptr_d = rd_ptr_q + PW'(1);
    if (push)     wr_ptr_d = wr_ptr_q + PW'(1);
    if (push & ~pop) count_d = count_q + CW'(1);
    if (pop & ~push) count_d = count_q - CW'(1);
    if (flush_now) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end

    if (underrun) underflow_d = 1'b1;
    if (push) begin
      pushed_d = pushed_q + 16'd1;
      if (sm_tlast) last_seen_d = 1'b1;
    end
    // A clear beats a coincident tlast push.
    if (clear_now) begin
      last_seen_d = 1'b0;
      underflow_d = 1'b0;
      pushed_d    = '0;
    end
  end

  // State registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (wb_rst_i) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      last_seen_q <= 1'b0;
      underflow_q <= 1'b0;
      pushed_q    <= '0;
    end else begin
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      last_seen_q <= last_seen_d;
      underflow_q <= underflow_d;
      pushed_q    <= pushed_d;
    end
  end

  // Sample storage
  always_ff @(posedge wb_clk_i) begin
    // NOTE: the storage array has no reset; an entry is only ever read
    // after it has been written, as guarded by count.
    if (push) fifo_mem[wr_ptr_q] <= {sm_tlast, sm_tdata};
  end

endmodule

// File: tb/tb_fir_sm_rdbuf.sv
// Bench for fir_sm_rdbuf: directed scenarios plus a randomized phase,
// checked every cycle against a queue-based model of the buffer.
module tb_fir_sm_rdbuf;

  localparam int DEPTH = 16;
  localparam logic [31:0] A_Y = 32'h3000_0080;
  localparam logic [31:0] A_S = 32'h3000_0084;
  localparam logic [31:0] A_C = 32'h3000_0088;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = '0, wdat = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        sm_tvalid = 1'b0, sm_tlast = 1'b0;
  logic [31:0] sm_tdata = '0;
  logic        sm_tready, frame_done_o;

  always #5 clk = ~clk;

  fir_sm_rdbuf #(.pDATA_WIDTH(32), .pDEPTH_LOG2(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
    .sm_tready(sm_tready), .frame_done_o(frame_done_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [32:0] m_q[$];
  bit          m_last_seen = 0, m_underflow = 0, m_ack = 0, m_ack_rd = 0, m_push_last = 0;
  logic [15:0] m_pushed = '0;
  logic [31:0] m_dat = '0;

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    logic [32:0] h;
    s = '0;
    s[0] = (m_q.size() == 0);
    s[1] = (m_q.size() == DEPTH);
    s[2] = m_last_seen;
    s[3] = m_underflow;
    if (m_q.size() > 0) begin
      h = m_q[0];
      s[4] = h[32];
    end
    s[15:8]  = 8'(m_q.size());
    s[31:16] = m_pushed;
    return s;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_last_seen = 0; m_underflow = 0; m_ack = 0; m_ack_rd = 0; m_push_last = 0;
    m_pushed = '0; m_dat = '0;
  endtask

  task automatic model_step();
    bit req, hit, rd, flush, clr, push;
    logic [31:0] rv;
    logic [32:0] e;
    req   = cyc && stb && !m_ack;
    hit   = (adr == A_Y) || (adr == A_S) || (adr == A_C);
    rd    = req && hit && !we;
    flush = req && we && (adr == A_C) && wdat[0];
    clr   = req && we && (adr == A_C) && wdat[1];
    push  = sm_tvalid && (m_q.size() < DEPTH) && !flush;
    rv = '0;
    if (rd && adr == A_S) rv = m_status();
    if (rd && adr == A_Y) begin
      if (m_q.size() > 0) begin
        e  = m_q.pop_front();
        rv = e[31:0];
      end else m_underflow = 1;
    end
    if (flush) m_q.delete();
    if (push) begin
      m_q.push_back({sm_tlast, sm_tdata});
      m_pushed = m_pushed + 16'd1;
      if (sm_tlast) m_last_seen = 1;
    end
    if (clr) begin
      m_last_seen = 0; m_underflow = 0; m_pushed = '0;
    end
    m_push_last = push;
    m_ack       = req && hit;
    m_ack_rd    = rd;
    if (rd) m_dat = rv;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else model_step();
  end

  // Per-cycle comparison, mid-cycle when inputs and outputs are settled
  initial forever begin
    bit flush_now;
    @(negedge clk);
    #3;
    flush_now = cyc && stb && !m_ack && we && (adr == A_C) && wdat[0];
    check("ack", wbs_ack_o, m_ack);
    check("tready", sm_tready, (m_q.size() < DEPTH) && !flush_now);
    check("frame_done", frame_done_o, m_last_seen);
    if (m_ack_rd) check("rdata", wbs_dat_o, m_dat);
  end

  // ---------------- stream source ----------------
  logic [32:0] src_q[$];
  int          src_rate = 100;

  initial forever begin
    logic [32:0] s;
    @(negedge clk);
    if (rst) sm_tvalid = 1'b0;
    else if (!sm_tvalid || m_push_last) begin
      if (src_q.size() > 0 && $urandom_range(99) < src_rate) begin
        s = src_q.pop_front();
        {sm_tlast, sm_tdata} = s;
        sm_tvalid = 1'b1;
      end else sm_tvalid = 1'b0;
    end
  end

  // ---------------- bus tasks ----------------
  task automatic wb_access(input bit w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd);
    bit got;
    got = 0;
    rd  = '0;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      #1;
      if (wbs_ack_o) begin
        got = 1;
        rd  = wbs_dat_o;
      end
    end
    cyc = 0; stb = 0; we = 0;
    check("wb_ack_seen", got, 1);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] rd);
    wb_access(0, a, '0, rd);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] unused_rd;
    wb_access(1, a, d, unused_rd);
  endtask

  // Holds a request for a fixed number of cycles and counts acks seen
  task automatic bus_hold(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input int cycles, output int acks);
    acks = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      if (wbs_ack_o) acks++;
    end
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wait_src_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      #2;
      if (src_q.size() == 0 && !sm_tvalid) ok = 1;
    end
    check("src_drain", ok, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    int acks;

    @(negedge clk);
    #2;
    check("ack_in_reset", wbs_ack_o, 0);
    check("dat_in_reset", wbs_dat_o, 0);
    repeat (2) @(negedge clk);
    rst = 0;

    // Reset state
    wb_read(A_S, r);
    check("status_reset", r, 32'h0000_0001);
    check("tready_reset", sm_tready, 1);
    check("frame_done_reset", frame_done_o, 0);

    // Three samples, last one tagged
    src_q.push_back({1'b0, 32'h11});
    src_q.push_back({1'b0, 32'h22});
    src_q.push_back({1'b1, 32'h33});
    wait_src_idle();
    wb_read(A_S, r); check("status_3", r, 32'h0003_0304);
    check("frame_done_set", frame_done_o, 1);
    wb_read(A_Y, r); check("ydata_0", r, 32'h11);
    wb_read(A_Y, r); check("ydata_1", r, 32'h22);
    wb_read(A_Y, r); check("ydata_2", r, 32'h33);
    wb_read(A_S, r); check("status_drained", r, 32'h0003_0005);

    // Fill to 16, 17th held off until one pop
    for (int i = 0; i < 16; i++) src_q.push_back({1'b0, 32'hA000 + 32'(i)});
    wait_src_idle();
    src_q.push_back({1'b0, 32'hBEEF});
    repeat (3) @(negedge clk);
    #2;
    check("tready_full", sm_tready, 0);
    check("valid_held", sm_tvalid, 1);
    wb_read(A_S, r); check("status_full", r, 32'h0013_1006);
    wb_read(A_Y, r); check("ydata_full_head", r, 32'hA000);
    wait_src_idle();
    wb_read(A_S, r); check("status_refill", r, 32'h0014_1006);

    // Flush, underflow, clear
    wb_write(A_C, 32'h1);
    wb_read(A_S, r); check("status_flushed", r, 32'h0014_0005);
    wb_read(A_Y, r); check("ydata_empty", r, 32'h0);
    wb_read(A_S, r); check("status_underflow", r, 32'h0014_000D);
    wb_write(A_C, 32'h2);
    wb_read(A_S, r); check("status_cleared", r, 32'h0000_0001);
    check("frame_done_cleared", frame_done_o, 0);

    // Push and pop in the same cycle at count 1, wrapping the pointers
    src_q.push_back({1'b0, 32'hC000});
    wait_src_idle();
    for (int k = 1; k <= 20; k++) begin
      src_q.push_back({(k == 20), 32'hC000 + 32'(k)});
      wb_read(A_Y, r);
      check("pushpop_data", r, 32'hC000 + 32'(k - 1));
    end
    wb_read(A_S, r); check("status_pushpop", r, 32'h0015_0114);
    wb_read(A_Y, r); check("pushpop_last", r, 32'hC014);

    // Flush while a sample is presented
    src_q.push_back({1'b0, 32'hD0});
    src_q.push_back({1'b0, 32'hD1});
    wait_src_idle();
    src_q.push_back({1'b0, 32'hD2});
    fork
      begin
        @(negedge clk);
        #2;
        check("tready_flush", sm_tready, 0);
      end
    join_none
    wb_write(A_C, 32'h1);
    wb_read(A_S, r); check("status_after_flush", r, 32'h0018_0104);
    wb_read(A_Y, r); check("held_sample", r, 32'hD2);

    // Strobe held: one ack every two cycles
    bus_hold(0, A_S, '0, 4, acks);
    check("held_stb_acks", acks, 2);

    // Foreign addresses are never acked and change nothing
    bus_hold(0, 32'h3000_008C, '0, 3, acks);
    check("bad_adr_read", acks, 0);
    bus_hold(1, 32'h3000_0000, 32'h3, 3, acks);
    check("bad_adr_write", acks, 0);
    wb_read(A_S, r); check("status_untouched", r, 32'h0018_0005);

    // Reset with data buffered and a read pending
    src_q.push_back({1'b1, 32'hE0});
    src_q.push_back({1'b0, 32'hE1});
    wait_src_idle();
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = A_Y;
    #1 rst = 1;
    @(negedge clk);
    cyc = 0; stb = 0;
    #1;
    check("no_ack_on_reset", wbs_ack_o, 0);
    @(negedge clk);
    rst = 0;
    wb_read(A_S, r); check("status_post_reset", r, 32'h0000_0001);

    // Randomized traffic
    src_rate = 60;
    for (int n = 0; n < 400; n++) begin
      int op;
      while (src_q.size() < 4)
        src_q.push_back({($urandom_range(7) == 0), $urandom()});
      op = $urandom_range(0, 9);
      if (op <= 4) wb_read(A_Y, r);
      else if (op <= 6) wb_read(A_S, r);
      else if (op == 7)
        wb_write(A_C, {30'b0, ($urandom_range(3) == 0), ($urandom_range(7) == 0)});
      else if (op == 8) wb_write(($urandom_range(1) == 0) ? A_Y : A_S, $urandom());
      else repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    src_q.delete();
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
